led_pio_sequencer: RTL and testbench

Avalon-MM LED pattern sequencer that sits between the Nios II data master and the 2-bit LED PIO output slave. The Nios writes a pattern table, step period and mode through a small configuration slave. The block then drives the PIO's s1 write port, stepping through the patterns in hardware. A direct-write path lets software still set the LEDs immediately; when both sources want the PIO in the same cycle, the direct write wins and the sequencer write is delayed.

---
 rtl/led_pio_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_led_pio_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_sequencer.sv
// LED pattern sequencer driving the s1 write port of a 2-bit LED PIO.
// A direct software write path always takes priority over the stepping sequencer.
//
// state | meaning
// IDLE  | no sequencer activity
// ISSUE | sequencer pulse due this cycle (stalls while a direct write is pending)
// COUNT | counting down the step period
module led_pio_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_PERIOD  = 3'd1;
    localparam logic [2:0] A_PATTERN = 3'd2;
    localparam logic [2:0] A_LAST    = 3'd3;
    localparam logic [2:0] A_DIRECT  = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd5;

    logic [1:0]  state_q, state_d;
    logic        enable_q, enable_d;
    logic        oneshot_q, oneshot_d;
    logic [23:0] period_q, period_d;
    logic [7:0]  pattern_q, pattern_d;
    logic [1:0]  last_q, last_d;
    logic        done_q, done_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] cnt_q, cnt_d;
    logic        dir_pend_q, dir_pend_d;
    logic [1:0]  dir_data_q, dir_data_d;
    logic        pio_cs_q, pio_cs_d;
    logic [1:0]  pio_data_q, pio_data_d;

    logic        cfg_wr;
    logic        seq_fire;
    logic [23:0] reload;
    logic [1:0]  cur_pat;
    logic        unused_wdata;

    assign unused_wdata = ^cfg_writedata[31:24];
    assign cfg_wr       = cfg_chipselect & ~cfg_write_n;
    // A period of 0 behaves as 1, so the reload value saturates at 0.
    assign reload       = (period_q == 24'd0) ? 24'd0 : period_q - 24'd1;

    always_comb begin
        cur_pat = 2'd0;
        case (idx_q)
            2'd0: cur_pat = pattern_q[1:0];
            2'd1: cur_pat = pattern_q[3:2];
            2'd2: cur_pat = pattern_q[5:4];
            2'd3: cur_pat = pattern_q[7:6];
            default: cur_pat = 2'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        oneshot_d  = oneshot_q;
        period_d   = period_q;
        pattern_d  = pattern_q;
        last_d     = last_q;
        done_d     = done_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        dir_pend_d = 1'b0;
        dir_data_d = dir_data_q;
        seq_fire   = 1'b0;

        if (cfg_wr) begin
            case (cfg_address)
                A_PERIOD:  period_d  = cfg_writedata[23:0];
                A_PATTERN: pattern_d = cfg_writedata[7:0];
                A_LAST:    last_d    = cfg_writedata[1:0];
                A_DIRECT: begin
                    dir_pend_d = 1'b1;
                    dir_data_d = cfg_writedata[1:0];
                end
                A_STATUS: if (cfg_writedata[1]) done_d = 1'b0;
                default: ;
            endcase
        end

        if (cfg_wr && cfg_address == A_CTRL) begin
            // A CTRL write overrides whatever the FSM would have done this cycle.
            enable_d  = cfg_writedata[0];
            oneshot_d = cfg_writedata[1];
            if (cfg_writedata[0]) begin
                idx_d   = 2'd0;
                done_d  = 1'b0;
                state_d = S_ISSUE;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (!dir_pend_q) begin
                        seq_fire = 1'b1;
                        cnt_d    = reload;
                        if (oneshot_q && idx_q == last_q) begin
                            done_d   = 1'b1;
                            enable_d = 1'b0;
                            state_d  = S_IDLE;
                        end else begin
                            idx_d   = (idx_q >= last_q) ? 2'd0 : idx_q + 2'd1;
                            state_d = (reload == 24'd0) ? S_ISSUE : S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    cnt_d = cnt_q - 24'd1;
                    if (cnt_q <= 24'd1) state_d = S_ISSUE;
                end
                default: ;
            endcase
        end

        pio_cs_d   = dir_pend_q | seq_fire;
        pio_data_d = dir_pend_q ? dir_data_q : (seq_fire ? cur_pat : pio_data_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            enable_q   <= 1'b0;
            oneshot_q  <= 1'b0;
            period_q   <= 24'd0;
            pattern_q  <= 8'd0;
            last_q     <= 2'd0;
            done_q     <= 1'b0;
            idx_q      <= 2'd0;
            cnt_q      <= 24'd0;
            dir_pend_q <= 1'b0;
            dir_data_q <= 2'd0;
            pio_cs_q   <= 1'b0;
            pio_data_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            oneshot_q  <= oneshot_d;
            period_q   <= period_d;
            pattern_q  <= pattern_d;
            last_q     <= last_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dir_pend_q <= dir_pend_d;
            dir_data_q <= dir_data_d;
            pio_cs_q   <= pio_cs_d;
            pio_data_q <= pio_data_d;
        end
    end

    always_comb begin
        cfg_readdata = 32'd0;
        case (cfg_address)
            A_CTRL:    cfg_readdata = {30'd0, oneshot_q, enable_q};
            A_PERIOD:  cfg_readdata = {8'd0, period_q};
            A_PATTERN: cfg_readdata = {24'd0, pattern_q};
            A_LAST:    cfg_readdata = {30'd0, last_q};
            A_STATUS:  cfg_readdata = {28'd0, idx_q, done_q, (state_q != S_IDLE)};
            default:   cfg_readdata = 32'd0;
        endcase
    end

    assign pio_address    = 2'd0;
    assign pio_chipselect = pio_cs_q;
    assign pio_write_n    = ~pio_cs_q;
    assign pio_writedata  = {30'd0, pio_data_q};

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed testbench for led_pio_sequencer; PIO pulses are logged by cycle and compared
// against hand-computed schedules.
module tb_led_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_write_n;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int q_cyc[$];
    int q_dat[$];

    led_pio_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_address    (cfg_address),
        .cfg_chipselect (cfg_chipselect),
        .cfg_write_n    (cfg_write_n),
        .cfg_writedata  (cfg_writedata),
        .cfg_readdata   (cfg_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every PIO pulse and check the strobe/address relationship during it.
    always @(negedge clk) begin
        if (pio_chipselect === 1'b1) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(int'(pio_writedata));
            checks++;
            if (pio_write_n !== 1'b0 || pio_address !== 2'd0 || pio_writedata[31:2] !== 30'd0) begin
                failures++;
                $display("FAIL pulse_strobe cyc=%0d write_n=%b address=%0d writedata=%h (want write_n=0 address=0 upper bits 0)",
                         cyc, pio_write_n, pio_address, pio_writedata);
            end
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d, output int edge_n);
        cfg_address    = a;
        cfg_writedata  = d;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b0;
        @(posedge clk);
        #1;
        edge_n         = cyc;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        cfg_address = a;
        #1;
        v = cfg_readdata;
    endtask

    task automatic clear_log();
        q_cyc.delete();
        q_dat.delete();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n        = 1'b0;
        cfg_address    = 3'd0;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
        cfg_writedata  = 32'd0;
        #12;
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_address !== 2'd0 || pio_writedata !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs cs=%b wn=%b addr=%0d wdata=%h want 0/1/0/0",
                     pio_chipselect, pio_write_n, pio_address, pio_writedata);
        end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            checks++;
            if (v !== 32'd0) begin
                failures++;
                $display("FAIL reset_reg addr=%0d got=%h want=0", a, v);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_regs();
        logic [31:0] v;
        int n;
        cfg_write(3'd1, 32'hFF12_3456, n);
        rd(3'd1, v);
        checks++;
        if (v !== 32'h0012_3456) begin failures++; $display("FAIL period_rd got=%h want=00123456", v); end
        cfg_write(3'd2, 32'h00AB_CDE4, n);
        rd(3'd2, v);
        checks++;
        if (v !== 32'h0000_00E4) begin failures++; $display("FAIL pattern_rd got=%h want=000000e4", v); end
        cfg_write(3'd3, 32'h0000_0007, n);
        rd(3'd3, v);
        checks++;
        if (v !== 32'd3) begin failures++; $display("FAIL last_rd got=%h want=3", v); end
        cfg_write(3'd0, 32'h0000_0006, n);
        rd(3'd0, v);
        checks++;
        if (v !== 32'd2) begin failures++; $display("FAIL ctrl_rd got=%h want=2", v); end
        cfg_write(3'd0, 32'd0, n);
        for (int a = 6; a < 8; a++) begin
            rd(3'(a), v);
            checks++;
            if (v !== 32'd0) begin failures++; $display("FAIL unmapped_rd addr=%0d got=%h want=0", a, v); end
        end
        // Direct write: pending cycle, one-cycle pulse, then data held.
        cfg_write(3'd4, 32'hFFFF_FFF1, n);
        checks++;
        if (pio_chipselect !== 1'b0) begin failures++; $display("FAIL direct_early cs=%b want=0", pio_chipselect); end
        wait_cycles(1);
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'd1) begin
            failures++; $display("FAIL direct_pulse cs=%b data=%h want cs=1 data=1", pio_chipselect, pio_writedata);
        end
        wait_cycles(1);
        checks++;
        if (pio_chipselect !== 1'b0 || pio_writedata !== 32'd1) begin
            failures++; $display("FAIL direct_hold cs=%b data=%h want cs=0 data=1", pio_chipselect, pio_writedata);
        end
        rd(3'd4, v);
        checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL direct_rd got=%h want=0", v); end
        rd(3'd5, v);
        checks++;
        if (v !== 32'd0) begin failures++; $display("FAIL status_idle got=%h want=0", v); end
    endtask

    task automatic test_sequence();
        int n, m;
        int exp_off[5] = '{1, 5, 9, 13, 17};
        int exp_d[5]   = '{0, 1, 2, 3, 0};
        cfg_write(3'd2, 32'hE4, m);
        cfg_write(3'd3, 32'd3, m);
        cfg_write(3'd1, 32'd4, m);
        clear_log();
        cfg_write(3'd0, 32'd1, n);
        wait_cycles(19);
        cfg_write(3'd0, 32'd0, m);
        wait_cycles(4);
        checks++;
        if (q_cyc.size() != 5) begin failures++; $display("FAIL seq_count got=%0d want=5", q_cyc.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= q_cyc.size()) begin
                failures++; $display("FAIL seq_pulse%0d missing want cyc=%0d data=%0d", i, n + exp_off[i], exp_d[i]);
            end else if (q_cyc[i] != n + exp_off[i] || q_dat[i] != exp_d[i]) begin
                failures++; $display("FAIL seq_pulse%0d got cyc=%0d data=%0d want cyc=%0d data=%0d",
                                     i, q_cyc[i], q_dat[i], n + exp_off[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        int n, m;
        int exp_off[2] = '{1, 3};
        int exp_d[2]   = '{0, 3};
        cfg_write(3'd2, 32'h9C, m);
        cfg_write(3'd3, 32'd1, m);
        cfg_write(3'd1, 32'd2, m);
        clear_log();
        cfg_write(3'd0, 32'd3, n);
        wait_cycles(8);
        checks++;
        if (q_cyc.size() != 2) begin failures++; $display("FAIL oneshot_count got=%0d want=2", q_cyc.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= q_cyc.size()) begin
                failures++; $display("FAIL oneshot_pulse%0d missing want cyc=%0d data=%0d", i, n + exp_off[i], exp_d[i]);
            end else if (q_cyc[i] != n + exp_off[i] || q_dat[i] != exp_d[i]) begin
                failures++; $display("FAIL oneshot_pulse%0d got cyc=%0d data=%0d want cyc=%0d data=%0d",
                                     i, q_cyc[i], q_dat[i], n + exp_off[i], exp_d[i]);
            end
        end
        rd(3'd5, v);
        checks++;
        if (v !== 32'd6) begin failures++; $display("FAIL oneshot_status got=%h want=6", v); end
        rd(3'd0, v);
        checks++;
        if (v !== 32'd2) begin failures++; $display("FAIL oneshot_ctrl got=%h want=2", v); end
        checks++;
        if (pio_writedata !== 32'd3) begin failures++; $display("FAIL oneshot_hold got=%h want=3", pio_writedata); end
        cfg_write(3'd5, 32'd2, m);
        rd(3'd5, v);
        checks++;
        if (v !== 32'd4) begin failures++; $display("FAIL done_clear got=%h want=4", v); end
    endtask

    task automatic test_direct_stall();
        int n, m;
        int exp_off[6] = '{1, 4, 7, 8, 11, 14};
        int exp_d[6]   = '{3, 2, 2, 1, 0, 3};
        cfg_write(3'd2, 32'h1B, m);
        cfg_write(3'd3, 32'd3, m);
        cfg_write(3'd1, 32'd3, m);
        clear_log();
        cfg_write(3'd0, 32'd1, n);
        wait_cycles(5);
        cfg_write(3'd4, 32'd2, m);
        wait_cycles(9);
        cfg_write(3'd0, 32'd0, m);
        wait_cycles(3);
        checks++;
        if (q_cyc.size() != 6) begin failures++; $display("FAIL stall_count got=%0d want=6", q_cyc.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= q_cyc.size()) begin
                failures++; $display("FAIL stall_pulse%0d missing want cyc=%0d data=%0d", i, n + exp_off[i], exp_d[i]);
            end else if (q_cyc[i] != n + exp_off[i] || q_dat[i] != exp_d[i]) begin
                failures++; $display("FAIL stall_pulse%0d got cyc=%0d data=%0d want cyc=%0d data=%0d",
                                     i, q_cyc[i], q_dat[i], n + exp_off[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_period_zero();
        int n, m;
        int exp_d[5] = '{0, 1, 2, 3, 0};
        cfg_write(3'd2, 32'hE4, m);
        cfg_write(3'd3, 32'd3, m);
        cfg_write(3'd1, 32'd0, m);
        clear_log();
        cfg_write(3'd0, 32'd1, n);
        wait_cycles(5);
        cfg_write(3'd0, 32'd0, m);
        checks++;
        if (pio_chipselect !== 1'b0) begin failures++; $display("FAIL p0_stop cs=%b want=0", pio_chipselect); end
        wait_cycles(4);
        checks++;
        if (q_cyc.size() != 5) begin failures++; $display("FAIL p0_count got=%0d want=5", q_cyc.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= q_cyc.size()) begin
                failures++; $display("FAIL p0_pulse%0d missing want cyc=%0d data=%0d", i, n + 1 + i, exp_d[i]);
            end else if (q_cyc[i] != n + 1 + i || q_dat[i] != exp_d[i]) begin
                failures++; $display("FAIL p0_pulse%0d got cyc=%0d data=%0d want cyc=%0d data=%0d",
                                     i, q_cyc[i], q_dat[i], n + 1 + i, exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, m;
        int exp_off[6] = '{1, 3, 5, 6, 7, 9};
        int exp_d[6]   = '{0, 1, 1, 3, 2, 3};
        cfg_write(3'd2, 32'hE4, m);
        cfg_write(3'd3, 32'd3, m);
        cfg_write(3'd1, 32'd2, m);
        clear_log();
        cfg_write(3'd0, 32'd1, n);
        wait_cycles(3);
        cfg_write(3'd4, 32'd1, m);
        cfg_write(3'd4, 32'd3, m);
        wait_cycles(5);
        cfg_write(3'd0, 32'd0, m);
        wait_cycles(3);
        checks++;
        if (q_cyc.size() != 6) begin failures++; $display("FAIL b2b_count got=%0d want=6", q_cyc.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= q_cyc.size()) begin
                failures++; $display("FAIL b2b_pulse%0d missing want cyc=%0d data=%0d", i, n + exp_off[i], exp_d[i]);
            end else if (q_cyc[i] != n + exp_off[i] || q_dat[i] != exp_d[i]) begin
                failures++; $display("FAIL b2b_pulse%0d got cyc=%0d data=%0d want cyc=%0d data=%0d",
                                     i, q_cyc[i], q_dat[i], n + exp_off[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int n, m;
        cfg_write(3'd2, 32'hE7, m);
        cfg_write(3'd3, 32'd3, m);
        cfg_write(3'd1, 32'd10, m);
        cfg_write(3'd0, 32'd1, n);
        wait_cycles(3);
        checks++;
        if (pio_writedata !== 32'd3) begin failures++; $display("FAIL rst_pre data=%h want=3", pio_writedata); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs cs=%b wn=%b wdata=%h want 0/1/0", pio_chipselect, pio_write_n, pio_writedata);
        end
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), v);
            checks++;
            if (v !== 32'd0) begin failures++; $display("FAIL rst_mid_reg addr=%0d got=%h want=0", a, v); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        wait_cycles(30);
        checks++;
        if (q_cyc.size() != 0) begin failures++; $display("FAIL rst_quiet pulses=%0d want=0", q_cyc.size()); end
        cfg_write(3'd0, 32'd1, n);
        wait_cycles(1);
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'd0) begin
            failures++; $display("FAIL rst_restart cs=%b data=%h want cs=1 data=0", pio_chipselect, pio_writedata);
        end
        cfg_write(3'd0, 32'd0, m);
        wait_cycles(2);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_sequence();
        test_oneshot();
        test_direct_stall();
        test_period_zero();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
